// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle shared by masters and the memory responder.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 word-addressed memory responder with independent read and write FSMs.
module axi_mem_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned NUM_WORDS      = 1024
) (
  input logic   clk_i,
  input logic   rst_ni,
  AXI_BUS.Slave slave
);
  localparam int unsigned DATA_BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF        = $clog2(DATA_BYTES);
  localparam int unsigned IDX_W      = $clog2(NUM_WORDS);
  localparam logic [2:0]  MAX_SIZE   = 3'(OFF);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  BURST_RSVD  = 2'b11;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [AXI_DATA_WIDTH-1:0] mem [NUM_WORDS];

  // Address of the following beat; WRAP with an illegal len degrades to INCR.
  function automatic addr_t next_addr(addr_t a, logic [7:0] len, logic [2:0] size,
                                      logic [1:0] burst);
    addr_t step, mask;
    step = addr_t'(1) << size;
    mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
          next_addr = (a & ~mask) | ((a + step) & mask);
        else
          next_addr = a + step;
      default:     next_addr = a + step;
    endcase
  endfunction

  function automatic logic out_of_range(addr_t a);
    return (a >> (OFF + IDX_W)) != '0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(addr_t a);
    return a[OFF+IDX_W-1:OFF];
  endfunction

  function automatic logic [2:0] clamp_size(logic [2:0] s);
    return (s > MAX_SIZE) ? MAX_SIZE : s;
  endfunction

  // ---------------- write channel ----------------
  wstate_t                 w_state, w_state_next;
  logic [AXI_ID_WIDTH-1:0] w_id;
  addr_t                   w_addr;
  logic [7:0]              w_len, w_cnt;
  logic [2:0]              w_size;
  logic [1:0]              w_burst;
  logic                    w_err;
  logic                    w_beat, w_beat_err;

  assign slave.aw_ready = (w_state == W_IDLE);
  assign slave.w_ready  = (w_state == W_DATA);
  assign slave.b_valid  = (w_state == W_RESP);
  assign slave.b_id     = w_id;
  assign slave.b_resp   = w_err ? RESP_SLVERR : RESP_OKAY;
  assign slave.b_user   = '0;

  assign w_beat     = (w_state == W_DATA) && slave.w_valid;
  assign w_beat_err = out_of_range(w_addr) || (w_burst == BURST_RSVD);

  // Write FSM next state: a burst ends on w_last or after len+1 beats.
  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE: if (slave.aw_valid) w_state_next = W_DATA;
      W_DATA: if (slave.w_valid && (slave.w_last || w_cnt == w_len)) w_state_next = W_RESP;
      W_RESP: if (slave.b_ready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write FSM state and burst bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_next;
      if (w_state == W_IDLE && slave.aw_valid) begin
        w_id    <= slave.aw_id;
        w_addr  <= slave.aw_addr;
        w_len   <= slave.aw_len;
        w_size  <= clamp_size(slave.aw_size);
        w_burst <= slave.aw_burst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_beat) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (w_beat_err) w_err <= 1'b1;
      end
    end
  end

  // Byte-strobed memory write; storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_beat && !w_beat_err)
      for (int unsigned i = 0; i < DATA_BYTES; i++)
        if (slave.w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= slave.w_data[8*i +: 8];
  end

  // ---------------- read channel ----------------
  rstate_t                   r_state, r_state_next;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  addr_t                     r_addr, r_load_addr;
  logic [7:0]                r_len, r_cnt;
  logic [2:0]                r_size;
  logic [1:0]                r_burst, r_load_burst, r_resp;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic                      r_last, r_load, r_load_err;

  assign slave.ar_ready = (r_state == R_IDLE);
  assign slave.r_valid  = (r_state == R_DATA);
  assign slave.r_id     = r_id;
  assign slave.r_data   = r_data;
  assign slave.r_resp   = r_resp;
  assign slave.r_last   = r_last;
  assign slave.r_user   = '0;

  // The beat to load is either the first (from AR) or the successor of the current one.
  assign r_load_addr  = (r_state == R_IDLE) ? slave.ar_addr
                                            : next_addr(r_addr, r_len, r_size, r_burst);
  assign r_load_burst = (r_state == R_IDLE) ? slave.ar_burst : r_burst;
  assign r_load_err   = out_of_range(r_load_addr) || (r_load_burst == BURST_RSVD);
  assign r_load       = ((r_state == R_IDLE) && slave.ar_valid) ||
                        ((r_state == R_DATA) && slave.r_ready && r_cnt != r_len);

  // Read FSM next state: leave DATA once the last beat is accepted.
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE: if (slave.ar_valid) r_state_next = R_DATA;
      R_DATA: if (slave.r_ready && r_cnt == r_len) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read FSM state and registered beat data (sees memory before same-cycle writes).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_state_next;
      if (r_load) begin
        r_addr <= r_load_addr;
        r_data <= r_load_err ? '0 : mem[word_idx(r_load_addr)];
        r_resp <= r_load_err ? RESP_SLVERR : RESP_OKAY;
        if (r_state == R_IDLE) begin
          r_id    <= slave.ar_id;
          r_len   <= slave.ar_len;
          r_size  <= clamp_size(slave.ar_size);
          r_burst <= slave.ar_burst;
          r_cnt   <= '0;
          r_last  <= (slave.ar_len == 8'd0);
        end else begin
          r_cnt  <= r_cnt + 8'd1;
          r_last <= (r_cnt + 8'd1 == r_len);
        end
      end
    end
  end

  // Sideband fields the memory has no use for.
  logic unused_sideband;
  assign unused_sideband = ^{slave.aw_lock, slave.aw_cache, slave.aw_prot, slave.aw_qos,
                             slave.aw_region, slave.aw_atop, slave.aw_user, slave.w_user,
                             slave.ar_lock, slave.ar_cache, slave.ar_prot, slave.ar_qos,
                             slave.ar_region, slave.ar_user};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, errors, concurrency, reset.
module tb_axi_mem_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
            .AXI_USER_WIDTH(1)) bus ();

  axi_mem_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
                  .AXI_USER_WIDTH(1), .NUM_WORDS(1024)) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave(bus)
  );

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  task automatic bus_idle();
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = 3'd3; bus.aw_burst = INCR;
    bus.aw_lock = 0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0; bus.aw_region = '0;
    bus.aw_atop = '0; bus.aw_user = '0; bus.aw_valid = 0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0; bus.w_user = '0; bus.w_valid = 0;
    bus.b_ready = 0;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = 3'd3; bus.ar_burst = INCR;
    bus.ar_lock = 0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0; bus.ar_region = '0;
    bus.ar_user = '0; bus.ar_valid = 0;
    bus.r_ready = 0;
  endtask

  // Bus drivers: start at posedge+1, return at posedge+1 after the handshake edge.
  task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id);
    int n = 0;
    bus.aw_addr = a; bus.aw_len = len; bus.aw_size = 3'd3; bus.aw_burst = burst;
    bus.aw_id = id; bus.aw_valid = 1;
    @(negedge clk);
    while (!bus.aw_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.aw_ready) begin
      vec++; errs++; $display("FAIL aw_timeout: aw_ready=%b required 1", bus.aw_ready);
    end
    @(posedge clk); #1 bus.aw_valid = 0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id);
    int n = 0;
    bus.ar_addr = a; bus.ar_len = len; bus.ar_size = 3'd3; bus.ar_burst = burst;
    bus.ar_id = id; bus.ar_valid = 1;
    @(negedge clk);
    while (!bus.ar_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.ar_ready) begin
      vec++; errs++; $display("FAIL ar_timeout: ar_ready=%b required 1", bus.ar_ready);
    end
    @(posedge clk); #1 bus.ar_valid = 0;
  endtask

  task automatic put_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n = 0;
    bus.w_data = d; bus.w_strb = strb; bus.w_last = last; bus.w_valid = 1;
    @(negedge clk);
    while (!bus.w_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.w_ready) begin
      vec++; errs++; $display("FAIL w_timeout: w_ready=%b required 1", bus.w_ready);
    end
    @(posedge clk); #1 bus.w_valid = 0; bus.w_last = 0;
  endtask

  task automatic get_b(output logic [3:0] id, output logic [1:0] resp, output int lat);
    int n = 0;
    bus.b_ready = 1;
    @(negedge clk);
    while (!bus.b_valid && n < 50) begin @(negedge clk); n++; end
    lat = n;
    if (!bus.b_valid) begin
      vec++; errs++; $display("FAIL b_timeout: b_valid=%b required 1", bus.b_valid);
    end
    id = bus.b_id; resp = bus.b_resp;
    @(posedge clk); #1 bus.b_ready = 0;
  endtask

  // Collects one R beat; with stall, r_ready stays low one extra valid cycle.
  task automatic get_r(input bit stall, output logic [63:0] d, output logic [1:0] resp,
                       output logic last, output logic [3:0] id, output int lat,
                       output bit stable);
    int n = 0;
    stable = 1;
    bus.r_ready = 0;
    @(negedge clk);
    while (!bus.r_valid && n < 50) begin @(negedge clk); n++; end
    lat = n;
    if (!bus.r_valid) begin
      vec++; errs++; $display("FAIL r_timeout: r_valid=%b required 1", bus.r_valid);
    end
    d = bus.r_data; resp = bus.r_resp; last = bus.r_last; id = bus.r_id;
    if (stall) begin
      @(negedge clk);
      stable = bus.r_valid && (bus.r_data === d) && (bus.r_resp === resp) && (bus.r_last === last);
    end
    bus.r_ready = 1;
    @(posedge clk); #1 bus.r_ready = 0;
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 0;
    @(negedge clk);
    vec++;
    if ({bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last} !== 6'b110000) begin
      errs++; $display("FAIL reset_handshake: got %b want 110000",
        {bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last});
    end
    vec++;
    if ({bus.r_data, bus.r_resp, bus.b_resp, bus.r_id, bus.b_id, bus.r_user, bus.b_user} !== 78'd0) begin
      errs++; $display("FAIL reset_fields: r_data=%h r_resp=%b b_resp=%b r_id=%h b_id=%h want all 0",
        bus.r_data, bus.r_resp, bus.b_resp, bus.r_id, bus.b_id);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    vec++;
    if ({bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid} !== 5'b11000) begin
      errs++; $display("FAIL reset_release: got %b want 11000",
        {bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    send_aw(32'h40, 8'd0, INCR, 4'h5);
    put_w(64'h1122334455667788, 8'hFF, 1);
    get_b(id, rs, lat);
    vec++;
    if ({id, rs, lat[3:0]} !== {4'h5, 2'b00, 4'd0}) begin
      errs++; $display("FAIL single_b: id=%h resp=%b lat=%0d want id=5 resp=00 lat=0", id, rs, lat);
    end
    send_ar(32'h40, 8'd0, INCR, 4'h9);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if (d !== 64'h1122334455667788) begin
      errs++; $display("FAIL single_rdata: got %h want 1122334455667788", d);
    end
    vec++;
    if ({id, rs, l, lat[3:0]} !== {4'h9, 2'b00, 1'b1, 4'd0}) begin
      errs++; $display("FAIL single_rctl: id=%h resp=%b last=%b lat=%0d want 9/00/1/0", id, rs, l, lat);
    end
  endtask

  task automatic test_incr_stall();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    send_aw(32'h100, 8'd3, INCR, 4'h1);
    for (int i = 0; i < 4; i++) put_w(64'(i), 8'hFF, i == 3);
    get_b(id, rs, lat);
    vec++;
    if ({id, rs} !== {4'h1, 2'b00}) begin
      errs++; $display("FAIL incr_b: id=%h resp=%b want 1/00", id, rs);
    end
    send_ar(32'h100, 8'd3, INCR, 4'h2);
    for (int i = 0; i < 4; i++) begin
      get_r(1, d, rs, l, id, lat, st);
      vec++;
      if ({d, rs, l, st} !== {64'(i), 2'b00, (i == 3), 1'b1}) begin
        errs++; $display("FAIL incr_beat%0d: data=%h resp=%b last=%b stable=%b want %0d/00/%b/1",
          i, d, rs, l, st, i, (i == 3));
      end
    end
  endtask

  task automatic test_wrap_fixed();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    logic [63:0] exp_wrap [4];
    exp_wrap[0] = 64'd3; exp_wrap[1] = 64'd0; exp_wrap[2] = 64'd1; exp_wrap[3] = 64'd2;
    send_aw(32'h0, 8'd3, INCR, 4'h3);
    for (int i = 0; i < 4; i++) put_w(64'(i), 8'hFF, i == 3);
    get_b(id, rs, lat);
    send_ar(32'h18, 8'd3, WRAP, 4'h3);
    for (int i = 0; i < 4; i++) begin
      get_r(0, d, rs, l, id, lat, st);
      vec++;
      if ({d, l} !== {exp_wrap[i], (i == 3)}) begin
        errs++; $display("FAIL wrap_beat%0d: data=%h last=%b want %h/%b", i, d, l, exp_wrap[i], (i == 3));
      end
    end
    // FIXED burst: both beats hit the same word, the second one wins.
    send_aw(32'h200, 8'd1, FIXED, 4'h4);
    put_w(64'hA, 8'hFF, 0);
    put_w(64'hB, 8'hFF, 1);
    get_b(id, rs, lat);
    send_ar(32'h200, 8'd1, FIXED, 4'h4);
    for (int i = 0; i < 2; i++) begin
      get_r(0, d, rs, l, id, lat, st);
      vec++;
      if ({d, l} !== {64'hB, (i == 1)}) begin
        errs++; $display("FAIL fixed_beat%0d: data=%h last=%b want b/%b", i, d, l, (i == 1));
      end
    end
  endtask

  task automatic test_strobe();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    send_aw(32'h08, 8'd0, INCR, 4'h0);
    put_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1);
    get_b(id, rs, lat);
    send_aw(32'h08, 8'd0, INCR, 4'h0);
    put_w(64'h0, 8'h0F, 1);
    get_b(id, rs, lat);
    send_ar(32'h08, 8'd0, INCR, 4'h0);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if (d !== 64'hFFFF_FFFF_0000_0000) begin
      errs++; $display("FAIL strobe_rdata: got %h want ffffffff00000000", d);
    end
  endtask

  task automatic test_burst_end();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    // w_last before len: burst ends after two beats.
    send_aw(32'h500, 8'd3, INCR, 4'hA);
    put_w(64'h77, 8'hFF, 0);
    put_w(64'h88, 8'hFF, 1);
    get_b(id, rs, lat);
    vec++;
    if ({id, rs, lat[3:0]} !== {4'hA, 2'b00, 4'd0}) begin
      errs++; $display("FAIL early_last_b: id=%h resp=%b lat=%0d want a/00/0", id, rs, lat);
    end
    // len reached without w_last: burst still ends.
    send_aw(32'h600, 8'd1, INCR, 4'hB);
    put_w(64'h99, 8'hFF, 0);
    put_w(64'hAA, 8'hFF, 0);
    get_b(id, rs, lat);
    vec++;
    if ({id, rs, lat[3:0]} !== {4'hB, 2'b00, 4'd0}) begin
      errs++; $display("FAIL len_end_b: id=%h resp=%b lat=%0d want b/00/0", id, rs, lat);
    end
    send_ar(32'h500, 8'd1, INCR, 4'h0);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if (d !== 64'h77) begin errs++; $display("FAIL early_rd0: got %h want 77", d); end
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if ({d, l} !== {64'h88, 1'b1}) begin
      errs++; $display("FAIL early_rd1: data=%h last=%b want 88/1", d, l);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    send_aw(32'h300, 8'd0, INCR, 4'h0);
    put_w(64'hAAAA_0000_0000_AAAA, 8'hFF, 1);
    get_b(id, rs, lat);
    send_aw(32'h300, 8'd0, INCR, 4'h3);
    bus.w_data = 64'h5555_5555_5555_5555; bus.w_strb = 8'hFF; bus.w_last = 1; bus.w_valid = 1;
    bus.ar_addr = 32'h300; bus.ar_len = 8'd0; bus.ar_burst = INCR; bus.ar_id = 4'h6; bus.ar_valid = 1;
    @(negedge clk);
    vec++;
    if ({bus.w_ready, bus.ar_ready} !== 2'b11) begin
      errs++; $display("FAIL samecyc_ready: w_ready,ar_ready=%b want 11", {bus.w_ready, bus.ar_ready});
    end
    @(posedge clk); #1 bus.w_valid = 0; bus.w_last = 0; bus.ar_valid = 0;
    get_b(id, rs, lat);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if (d !== 64'hAAAA_0000_0000_AAAA) begin
      errs++; $display("FAIL samecyc_old: got %h want aaaa00000000aaaa", d);
    end
    send_ar(32'h300, 8'd0, INCR, 4'h6);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if (d !== 64'h5555_5555_5555_5555) begin
      errs++; $display("FAIL samecyc_new: got %h want 5555555555555555", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    send_aw(32'h2000, 8'd0, INCR, 4'h6);
    // In-range read while the write waits for its data beat.
    send_ar(32'h08, 8'd0, INCR, 4'h7);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if ({d, rs, l, id, lat[3:0]} !== {64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'h7, 4'd0}) begin
      errs++; $display("FAIL oor_concurrent_rd: data=%h resp=%b last=%b id=%h lat=%0d want ffffffff00000000/00/1/7/0",
        d, rs, l, id, lat);
    end
    put_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1);
    get_b(id, rs, lat);
    vec++;
    if ({id, rs} !== {4'h6, 2'b10}) begin
      errs++; $display("FAIL oor_b: id=%h resp=%b want 6/10", id, rs);
    end
    send_ar(32'h2000, 8'd0, INCR, 4'h8);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if ({d, rs, l} !== {64'h0, 2'b10, 1'b1}) begin
      errs++; $display("FAIL oor_r: data=%h resp=%b last=%b want 0/10/1", d, rs, l);
    end
    // The out-of-range address aliases word 0 in its low bits; word 0 must be untouched.
    send_ar(32'h0, 8'd0, INCR, 4'h8);
    get_r(0, d, rs, l, id, lat, st);
    vec++;
    if ({d, rs} !== {64'h0, 2'b00}) begin
      errs++; $display("FAIL oor_nowrite: word0=%h resp=%b want 0/00", d, rs);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int lat; bit st;
    send_aw(32'h400, 8'd3, INCR, 4'h2);
    put_w(64'h1111_1111_1111_1111, 8'hFF, 0);
    put_w(64'h2222_2222_2222_2222, 8'hFF, 0);
    rst_n = 0;
    @(negedge clk);
    vec++;
    if ({bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid, bus.b_id} !== 9'b11000_0000) begin
      errs++; $display("FAIL midrst_state: rdy/vld=%b b_id=%h want 11000/0",
        {bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid}, bus.b_id);
    end
    @(posedge clk); #1 rst_n = 1;
    send_aw(32'h410, 8'd0, INCR, 4'h4);
    put_w(64'h3333_3333_3333_3333, 8'hFF, 1);
    get_b(id, rs, lat);
    vec++;
    if ({id, rs, lat[3:0]} !== {4'h4, 2'b00, 4'd0}) begin
      errs++; $display("FAIL midrst_next_b: id=%h resp=%b lat=%0d want 4/00/0", id, rs, lat);
    end
    send_ar(32'h400, 8'd2, INCR, 4'h1);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] e;
      e = (i == 0) ? 64'h1111_1111_1111_1111 :
          (i == 1) ? 64'h2222_2222_2222_2222 : 64'h3333_3333_3333_3333;
      get_r(0, d, rs, l, id, lat, st);
      vec++;
      if ({d, rs, l} !== {e, 2'b00, (i == 2)}) begin
        errs++; $display("FAIL midrst_beat%0d: data=%h resp=%b last=%b want %h/00/%b", i, d, rs, l, e, (i == 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_stall();
    test_wrap_fixed();
    test_strobe();
    test_burst_end();
    test_same_cycle();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
